// File: rtl/reset_seq.sv
// rtl/reset_seq.sv - delayed system reset release plus staggered per-channel PHY reset sequencer
// Optional reset event counter is built only when RSTSEQ_EVT_CNT_EN is defined.
module reset_seq #(
    parameter int NPHY        = 2,
    parameter int SYS_DLY     = 1048576,
    parameter int PHY_HOLD    = 520,
    parameter int PHY_STAGGER = 16
) (
    input  logic            clk_125,
    input  logic            rstn,
    input  logic            ext_reset_n,
    input  logic [NPHY-1:0] soft_rst_req,
    output logic            sys_rst_n,
    output logic            sys_rst,
    output logic [NPHY-1:0] phy_rst_n,
    output logic            seq_done,
    output logic [7:0]      rst_evt_cnt
);
    localparam int YW = $clog2(SYS_DLY);
    localparam int HW = $clog2(PHY_HOLD);
    localparam int SW = (PHY_STAGGER > 1) ? $clog2(PHY_STAGGER) : 1;
    localparam int CW = (NPHY > 1) ? $clog2(NPHY) : 1;

    typedef enum logic [1:0] {P_HOLD, P_STAGGER, P_RUN} phy_state_e;

    phy_state_e      state_q, state_d;
    logic            ext_meta_q, ext_meta_d;
    logic            ext_sync_q, ext_sync_d;
    logic [YW-1:0]   sys_cnt_q, sys_cnt_d;
    logic            sys_rst_n_q, sys_rst_n_d;
    logic            sys_rst_q, sys_rst_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [SW-1:0]   stag_cnt_q, stag_cnt_d;
    logic [CW-1:0]   ch_q, ch_d;
    logic [HW-1:0]   soft_cnt_q [NPHY];
    logic [HW-1:0]   soft_cnt_d [NPHY];
    logic [NPHY-1:0] phy_rst_n_q, phy_rst_n_d;
    logic            seq_done_q, seq_done_d;

    always_comb begin
        ext_meta_d  = ext_reset_n;
        ext_sync_d  = ext_meta_q;
        sys_cnt_d   = sys_cnt_q;
        sys_rst_n_d = sys_rst_n_q;
        if (!sys_rst_n_q) begin
            if (sys_cnt_q == YW'(SYS_DLY - 1)) begin
                sys_rst_n_d = 1'b1;
            end else begin
                sys_cnt_d = sys_cnt_q + YW'(1);
            end
        end
        sys_rst_d = ~sys_rst_n_d;
    end

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        stag_cnt_d  = stag_cnt_q;
        ch_d        = ch_q;
        soft_cnt_d  = soft_cnt_q;
        phy_rst_n_d = phy_rst_n_q;
        // Board reset overrides everything, including a same-cycle soft request.
        if (!ext_sync_q) begin
            state_d     = P_HOLD;
            hold_cnt_d  = '0;
            stag_cnt_d  = '0;
            ch_d        = '0;
            phy_rst_n_d = '0;
            for (int i = 0; i < NPHY; i++) soft_cnt_d[i] = '0;
        end else begin
            case (state_q)
                P_HOLD: begin
                    if (hold_cnt_q == HW'(PHY_HOLD - 1)) begin
                        hold_cnt_d     = '0;
                        phy_rst_n_d[0] = 1'b1;
                        ch_d           = CW'(1);
                        state_d        = (NPHY == 1) ? P_RUN : P_STAGGER;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HW'(1);
                    end
                end
                P_STAGGER: begin
                    if (stag_cnt_q == SW'(PHY_STAGGER - 1)) begin
                        stag_cnt_d = '0;
                        for (int i = 0; i < NPHY; i++) begin
                            if (CW'(i) == ch_q) phy_rst_n_d[i] = 1'b1;
                        end
                        if (ch_q == CW'(NPHY - 1)) begin
                            state_d = P_RUN;
                        end else begin
                            ch_d = ch_q + CW'(1);
                        end
                    end else begin
                        stag_cnt_d = stag_cnt_q + SW'(1);
                    end
                end
                P_RUN: begin
                    // A new request while already held restarts that channel's hold.
                    for (int i = 0; i < NPHY; i++) begin
                        if (soft_rst_req[i]) begin
                            phy_rst_n_d[i] = 1'b0;
                            soft_cnt_d[i]  = '0;
                        end else if (!phy_rst_n_q[i]) begin
                            if (soft_cnt_q[i] == HW'(PHY_HOLD - 1)) begin
                                phy_rst_n_d[i] = 1'b1;
                            end else begin
                                soft_cnt_d[i] = soft_cnt_q[i] + HW'(1);
                            end
                        end
                    end
                end
                default: state_d = P_HOLD;
            endcase
        end
        seq_done_d = sys_rst_n_d & (&phy_rst_n_d);
    end

    always_ff @(posedge clk_125 or negedge rstn) begin
        if (!rstn) begin
            state_q     <= P_HOLD;
            ext_meta_q  <= 1'b0;
            ext_sync_q  <= 1'b0;
            sys_cnt_q   <= '0;
            sys_rst_n_q <= 1'b0;
            sys_rst_q   <= 1'b1;
            hold_cnt_q  <= '0;
            stag_cnt_q  <= '0;
            ch_q        <= '0;
            soft_cnt_q  <= '{default: '0};
            phy_rst_n_q <= '0;
            seq_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ext_meta_q  <= ext_meta_d;
            ext_sync_q  <= ext_sync_d;
            sys_cnt_q   <= sys_cnt_d;
            sys_rst_n_q <= sys_rst_n_d;
            sys_rst_q   <= sys_rst_d;
            hold_cnt_q  <= hold_cnt_d;
            stag_cnt_q  <= stag_cnt_d;
            ch_q        <= ch_d;
            soft_cnt_q  <= soft_cnt_d;
            phy_rst_n_q <= phy_rst_n_d;
            seq_done_q  <= seq_done_d;
        end
    end

    assign sys_rst_n = sys_rst_n_q;
    assign sys_rst   = sys_rst_q;
    assign phy_rst_n = phy_rst_n_q;
    assign seq_done  = seq_done_q;

`ifdef RSTSEQ_EVT_CNT_EN
    logic [7:0]      evt_cnt_q, evt_cnt_d;
    logic [NPHY-1:0] soft_acc;
    logic [8:0]      evt_sum;

    always_comb begin
        soft_acc = (state_q == P_RUN && ext_sync_q) ? soft_rst_req : '0;
        evt_sum  = {1'b0, evt_cnt_q} + {8'd0, ext_sync_q & ~ext_meta_q};
        for (int i = 0; i < NPHY; i++) evt_sum = evt_sum + {8'd0, soft_acc[i]};
        evt_cnt_d = (evt_sum > 9'd255) ? 8'd255 : evt_sum[7:0];
    end

    always_ff @(posedge clk_125 or negedge rstn) begin
        if (!rstn) begin
            evt_cnt_q <= 8'd0;
        end else begin
            evt_cnt_q <= evt_cnt_d;
        end
    end

    assign rst_evt_cnt = evt_cnt_q;
`else
    assign rst_evt_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_reset_seq.sv
// tb/tb_reset_seq.sv - self-checking bench for reset_seq against a release-time window model
module tb_reset_seq;
    localparam int NPHY        = 2;
    localparam int SYS_DLY     = 64;
    localparam int PHY_HOLD    = 520;
    localparam int PHY_STAGGER = 16;
    localparam int REL0        = 2 + PHY_HOLD;
    localparam int REL_LAST    = REL0 + (NPHY - 1) * PHY_STAGGER;
    localparam longint INF     = 64'sh3fff_ffff_ffff_ffff;
`ifdef RSTSEQ_EVT_CNT_EN
    localparam bit EVT_EN = 1'b1;
`else
    localparam bit EVT_EN = 1'b0;
`endif

    logic            clk_125      = 1'b0;
    logic            rstn         = 1'b0;
    logic            ext_reset_n  = 1'b1;
    logic [NPHY-1:0] soft_rst_req = '0;
    logic            sys_rst_n;
    logic            sys_rst;
    logic [NPHY-1:0] phy_rst_n;
    logic            seq_done;
    logic [7:0]      rst_evt_cnt;

    reset_seq #(
        .NPHY(NPHY), .SYS_DLY(SYS_DLY), .PHY_HOLD(PHY_HOLD), .PHY_STAGGER(PHY_STAGGER)
    ) dut (
        .clk_125(clk_125), .rstn(rstn), .ext_reset_n(ext_reset_n), .soft_rst_req(soft_rst_req),
        .sys_rst_n(sys_rst_n), .sys_rst(sys_rst), .phy_rst_n(phy_rst_n),
        .seq_done(seq_done), .rst_evt_cnt(rst_evt_cnt)
    );

    always #4 clk_125 = ~clk_125;

    // Model: each channel is low inside [lo_at, rel) measured in clock edges.
    longint cyc = 0;
    longint sys_rel = INF;
    longint run_at = INF;
    longint lo_at [NPHY];
    longint rel [NPHY];
    int     evt_exp = 0;
    longint evt_ext_at = -1;
    longint soft_add_at = -1;
    int     soft_add_n = 0;
    int     n_chk = 0;
    int     n_pass = 0;
    logic [12:0] obs, expv;

    function automatic logic [12:0] exp_vec();
        logic s;
        logic [NPHY-1:0] p;
        s = (cyc >= sys_rel);
        for (int i = 0; i < NPHY; i++) p[i] = !(lo_at[i] <= cyc && cyc < rel[i]);
        return {s, ~s, p, s & (&p), 8'(evt_exp)};
    endfunction

    function automatic bit in_window(input int i, input longint t);
        return (lo_at[i] <= t && t < rel[i]);
    endfunction

    task automatic evt_bump(input int n);
        if (EVT_EN) evt_exp = (evt_exp + n > 255) ? 255 : evt_exp + n;
    endtask

    task automatic tick();
        @(posedge clk_125);
        #1;
        cyc++;
        if (cyc == evt_ext_at) evt_bump(1);
        if (cyc == soft_add_at) evt_bump(soft_add_n);
        obs  = {sys_rst_n, sys_rst, phy_rst_n, seq_done, rst_evt_cnt};
        expv = exp_vec();
    endtask

    task automatic model_reset();
        sys_rel = INF;
        run_at  = INF;
        for (int i = 0; i < NPHY; i++) begin
            lo_at[i] = 0;
            rel[i]   = INF;
        end
        evt_exp     = 0;
        evt_ext_at  = -1;
        soft_add_at = -1;
    endtask

    task automatic phy_release(input longint base);
        for (int i = 0; i < NPHY; i++) rel[i] = base + REL0 + i * PHY_STAGGER;
        run_at = base + REL_LAST;
    endtask

    task automatic release_rstn();
        rstn    = 1'b1;
        sys_rel = cyc + SYS_DLY;
        phy_release(cyc);
    endtask

    task automatic release_ext();
        ext_reset_n = 1'b1;
        phy_release(cyc);
    endtask

    task automatic ext_fall();
        ext_reset_n = 1'b0;
        for (int i = 0; i < NPHY; i++) begin
            if (!in_window(i, cyc)) lo_at[i] = cyc + 3;
            rel[i] = INF;
        end
        run_at     = INF;
        evt_ext_at = cyc + 2;
    endtask

    task automatic drive_soft(input logic [NPHY-1:0] pat);
        longint e;
        int n;
        e = cyc + 1;
        n = 0;
        soft_rst_req = pat;
        if (e > run_at) begin
            for (int i = 0; i < NPHY; i++) begin
                if (pat[i]) begin
                    if (!in_window(i, cyc)) lo_at[i] = e;
                    rel[i] = e + PHY_HOLD;
                    n++;
                end
            end
            soft_add_n  = n;
            soft_add_at = e;
        end
        tick();
        soft_rst_req = '0;
    endtask

    task automatic test_reset();
        repeat (4) begin
            tick();
            n_chk++;
            if (obs !== expv) $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, obs, expv);
            else n_pass++;
        end
    endtask

    task automatic test_startup();
        release_rstn();
        repeat (REL_LAST + 20) begin
            tick();
            n_chk++;
            if (obs !== expv) $display("FAIL startup cyc=%0d got=%h exp=%h", cyc, obs, expv);
            else n_pass++;
        end
    endtask

    task automatic test_soft_single();
        drive_soft(2'b01);
        repeat (PHY_HOLD + 20) begin
            tick();
            n_chk++;
            if (obs !== expv) $display("FAIL soft_single cyc=%0d got=%h exp=%h", cyc, obs, expv);
            else n_pass++;
        end
    endtask

    task automatic test_soft_restart();
        drive_soft(2'b10);
        repeat (299) begin
            tick();
            n_chk++;
            if (obs !== expv) $display("FAIL soft_restart cyc=%0d got=%h exp=%h", cyc, obs, expv);
            else n_pass++;
        end
        drive_soft(2'b10);
        repeat (PHY_HOLD + 10) begin
            tick();
            n_chk++;
            if (obs !== expv) $display("FAIL soft_restart cyc=%0d got=%h exp=%h", cyc, obs, expv);
            else n_pass++;
        end
    endtask

    task automatic test_ext_reset();
        ext_fall();
        repeat (100) begin
            tick();
            n_chk++;
            if (obs !== expv) $display("FAIL ext_reset cyc=%0d got=%h exp=%h", cyc, obs, expv);
            else n_pass++;
        end
        release_ext();
        repeat (REL_LAST + 10) begin
            tick();
            n_chk++;
            if (obs !== expv) $display("FAIL ext_reset cyc=%0d got=%h exp=%h", cyc, obs, expv);
            else n_pass++;
        end
    endtask

    task automatic test_priority();
        ext_fall();
        repeat (2) begin
            tick();
            n_chk++;
            if (obs !== expv) $display("FAIL priority cyc=%0d got=%h exp=%h", cyc, obs, expv);
            else n_pass++;
        end
        drive_soft(2'b11);
        repeat (60) begin
            tick();
            n_chk++;
            if (obs !== expv) $display("FAIL priority cyc=%0d got=%h exp=%h", cyc, obs, expv);
            else n_pass++;
        end
        release_ext();
        repeat (REL_LAST + 10) begin
            tick();
            n_chk++;
            if (obs !== expv) $display("FAIL priority cyc=%0d got=%h exp=%h", cyc, obs, expv);
            else n_pass++;
        end
    endtask

    task automatic test_random_soft();
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(0, 600)) begin
                tick();
                n_chk++;
                if (obs !== expv) $display("FAIL random_soft cyc=%0d got=%h exp=%h", cyc, obs, expv);
                else n_pass++;
            end
            drive_soft(2'($urandom_range(1, 3)));
        end
        repeat (PHY_HOLD + 10) begin
            tick();
            n_chk++;
            if (obs !== expv) $display("FAIL random_soft cyc=%0d got=%h exp=%h", cyc, obs, expv);
            else n_pass++;
        end
    endtask

    task automatic test_evt_saturate();
        repeat (300) begin
            drive_soft(2'($urandom_range(1, 3)));
            n_chk++;
            if (obs !== expv) $display("FAIL evt_saturate cyc=%0d got=%h exp=%h", cyc, obs, expv);
            else n_pass++;
        end
        repeat (PHY_HOLD + 10) begin
            tick();
            n_chk++;
            if (obs !== expv) $display("FAIL evt_saturate cyc=%0d got=%h exp=%h", cyc, obs, expv);
            else n_pass++;
        end
        n_chk++;
        if (rst_evt_cnt !== (EVT_EN ? 8'd255 : 8'd0))
            $display("FAIL evt_final got=%0d exp=%0d", rst_evt_cnt, EVT_EN ? 255 : 0);
        else n_pass++;
    endtask

    task automatic test_rstn_mid();
        rstn = 1'b0;
        model_reset();
        #1;
        obs  = {sys_rst_n, sys_rst, phy_rst_n, seq_done, rst_evt_cnt};
        expv = exp_vec();
        n_chk++;
        if (obs !== expv) $display("FAIL rstn_async_run got=%h exp=%h", obs, expv);
        else n_pass++;
        repeat (3) tick();
        release_rstn();
        repeat (REL0 + PHY_STAGGER / 2) begin
            tick();
            n_chk++;
            if (obs !== expv) $display("FAIL rstn_mid cyc=%0d got=%h exp=%h", cyc, obs, expv);
            else n_pass++;
        end
        rstn = 1'b0;
        model_reset();
        #1;
        obs  = {sys_rst_n, sys_rst, phy_rst_n, seq_done, rst_evt_cnt};
        expv = exp_vec();
        n_chk++;
        if (obs !== expv) $display("FAIL rstn_async_stagger got=%h exp=%h", obs, expv);
        else n_pass++;
        repeat (3) begin
            tick();
            n_chk++;
            if (obs !== expv) $display("FAIL rstn_low cyc=%0d got=%h exp=%h", cyc, obs, expv);
            else n_pass++;
        end
        release_rstn();
        repeat (REL_LAST + 20) begin
            tick();
            n_chk++;
            if (obs !== expv) $display("FAIL rstn_restart cyc=%0d got=%h exp=%h", cyc, obs, expv);
            else n_pass++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_startup();
        test_soft_single();
        test_soft_restart();
        test_ext_reset();
        test_priority();
        test_random_soft();
        test_evt_saturate();
        test_rstn_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/reset_seq.md
RESET_SEQ -- requirements
Module: reset_seq

Interface
REQ-001 The block SHALL have parameter NPHY, default 2, meaning the number of PHY reset channels (range 1..8).
REQ-002 The block SHALL have parameter SYS_DLY, default 1048576, meaning the number of cycles from rstn release to sys_rst_n high (minimum 2).
REQ-003 The block SHALL have parameter PHY_HOLD, default 520, meaning the number of cycles a PHY reset is held (minimum 2).
REQ-004 The block SHALL have parameter PHY_STAGGER, default 16, meaning the number of cycles between successive channel releases (minimum 1).
REQ-005 The block SHALL have port clk_125, input, 1 bit: the 125 MHz system clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rstn, input, 1 bit: the reset, asynchronous, active-low.
REQ-007 The block SHALL have port ext_reset_n, input, 1 bit: the asynchronous board PHY reset button, active-low.
REQ-008 The block SHALL have port soft_rst_req, input, NPHY bits: per-channel single-cycle soft-reset request pulses.
REQ-009 The block SHALL have port sys_rst_n, output, 1 bit: the delayed system reset release.
REQ-010 The block SHALL have port sys_rst, output, 1 bit: always the inverse of sys_rst_n.
REQ-011 The block SHALL have port phy_rst_n, output, NPHY bits: the per-channel PHY reset, active-low.
REQ-012 The block SHALL have port seq_done, output, 1 bit: high when sys_rst_n is high and all phy_rst_n bits are high.
REQ-013 The block SHALL have port rst_evt_cnt, output, 8 bits: the reset event count (see Configuration).

Function
REQ-014 A sys counter SHALL start at rstn release, and sys_rst_n SHALL rise exactly SYS_DLY clock edges after rstn release, then hold until rstn asserts.
REQ-015 sys_rst_n SHALL be unaffected by ext_reset_n and by soft_rst_req.
REQ-016 ext_reset_n SHALL pass through a 2-flop synchronizer (ext_sync), and all outputs SHALL be registered.
REQ-017 The PHY FSM SHALL have the states P_HOLD, P_STAGGER and P_RUN, and SHALL enter P_HOLD on reset.
REQ-018 In P_HOLD, with ext_sync low, the hold counter SHALL stay at 0; with ext_sync high, it SHALL increment.
REQ-019 When the hold counter reaches PHY_HOLD, the FSM SHALL set phy_rst_n[0] high and go to P_STAGGER; channel 0 is released PHY_HOLD edges after the first edge with ext_sync high.
REQ-020 In P_STAGGER, channel i SHALL be released PHY_STAGGER edges after channel i-1; after channel NPHY-1 is released, the FSM SHALL go to P_RUN; with NPHY=1 it SHALL go directly to P_RUN.
REQ-021 In any state, ext_sync low SHALL drive all phy_rst_n low, clear all counters, cancel soft resets and return the FSM to P_HOLD; phy_rst_n SHALL be low by the 3rd edge after ext_reset_n falls.
REQ-022 In P_RUN, soft_rst_req[i] high SHALL drive phy_rst_n[i] low on the next edge and hold it low for exactly PHY_HOLD cycles, then release it; other channels SHALL be unaffected.
REQ-023 A soft_rst_req[i] arriving during channel i's soft reset SHALL restart its PHY_HOLD count.
REQ-024 soft_rst_req SHALL be ignored outside P_RUN.
REQ-025 When ext_sync falls in the same cycle as a soft_rst_req, ext_sync SHALL take priority.
REQ-026 seq_done SHALL drop in the same cycle any phy_rst_n bit drops.

Reset
REQ-027 While rstn is low, the outputs SHALL be: sys_rst_n=0, sys_rst=1, phy_rst_n=all 0, seq_done=0, rst_evt_cnt=0.
REQ-028 While rstn is low, the FSM SHALL be in P_HOLD, all counters and synchronizer flops SHALL be 0, and the block SHALL restart the full sequence on rstn release.
REQ-029 rstn asserted mid-sequence or in P_RUN SHALL take effect immediately and asynchronously on all outputs.

Configuration
REQ-030 With macro RSTSEQ_EVT_CNT_EN defined, rst_evt_cnt SHALL increment once per ext_sync falling edge and once per accepted soft_rst_req bit (a simultaneous request on k channels adds k), saturating at 255.
REQ-031 Without macro RSTSEQ_EVT_CNT_EN, rst_evt_cnt SHALL be constant 8'd0 and no counter logic SHALL be built.

Verification (NPHY=2, SYS_DLY=64, PHY_HOLD=520, PHY_STAGGER=16, ext_reset_n=1 unless stated)
REQ-032 Release rstn -> sys_rst_n rises at edge 64; phy_rst_n[0] rises at edge 522 (2 synchronizer edges plus 520) and phy_rst_n[1] at edge 538; seq_done rises at edge 538.
REQ-033 In P_RUN, pulse soft_rst_req=2'b01 -> phy_rst_n[0] is low for exactly 520 cycles, phy_rst_n[1] stays high, seq_done is low for the same 520 cycles, and rst_evt_cnt=1 (with the macro).
REQ-034 Hold ext_reset_n low for 100 cycles in P_RUN -> both phy_rst_n are low by the 3rd edge and re-release 522 and 538 edges after ext_reset_n rises; sys_rst_n stays high throughout.
REQ-035 Re-pulse soft_rst_req[1] 300 cycles into its soft reset -> phy_rst_n[1] stays low for a total of 820 cycles.
REQ-036 Assert rstn during P_STAGGER -> all outputs return to reset values asynchronously, and the full sequence repeats with the REQ-032 timing.
REQ-037 Issue 300 soft requests -> rst_evt_cnt saturates at 255 with the macro and reads 0 without it.
